mao_pontuacao: RTL and testbench
================================

MAO_PONTUACAO -- requirements
Module: mao_pontuacao

Interface
REQ-001 Parameter N_CARTAS, default 52: deck size; valid addresses are 0..N_CARTAS-1.
REQ-002 Parameter LIMITE, default 21: highest non-bust score.
REQ-003 Port list, clock and reset first:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-low.
- embaralhar_ok  in  1  deck shuffled and readable.
- novo_jogo  in  1  1-cycle pulse; clears both hands.
- comprar  in  1  1-cycle draw request.
- destino  in  1  0 = player hand, 1 = dealer hand; sampled with comprar.
- q  in  4  card code from deck at ler_endereco, combinational: 1 = ace, 2..10 = face value, 11 = J/Q/K.
- ler_endereco  out  6  deck read pointer.
- carta  out  4  code of the last card dealt.
- carta_valida  out  1  1-cycle pulse when a card has been scored.
- ocupado  out  1  draw in progress.
- pontos_jogador, pontos_dealer  out  5 each  best score per hand.
- estouro_jogador, estouro_dealer  out  1 each  score > LIMITE.
- baralho_vazio  out  1  ler_endereco == N_CARTAS.

Function
REQ-004 FSM states: IDLE, LER, SOMAR.
- IDLE -> LER on an accepted comprar.
- LER -> SOMAR unconditionally.
- SOMAR -> IDLE unconditionally.
REQ-005 Acceptance: comprar is accepted only in IDLE, and only when embaralhar_ok=1, baralho_vazio=0, the selected hand's estouro=0 and novo_jogo=0; any other comprar is dropped without effect.
REQ-006 destino is latched on acceptance.
REQ-007 LER: register q into carta.
REQ-008 SOMAR: add the card to the latched hand; ler_endereco increments by 1; carta_valida=1 for exactly this cycle.
REQ-009 Latency: comprar accepted at edge N -> carta_valida high in cycle N+2, with scores updated in the same cycle; next acceptance possible at edge N+3.
REQ-010 ocupado=1 in LER and SOMAR, 0 in IDLE.
REQ-011 ler_endereco holds the next undealt card; it is never cleared by novo_jogo (the deck carries across rounds); it saturates at N_CARTAS.
REQ-012 Card points: code 1 -> 1; codes 2..10 -> face value; code 11 -> 10; code 0 or 12..15 -> 0, and the card is still consumed.
REQ-013 Per hand, keep a 5-bit hard sum and an ace flag; hard sum saturates at 31.
REQ-014 pontos = hard + 10 when (ace flag and hard <= 11), else hard.
REQ-015 estouro = (pontos > LIMITE); outputs are combinational from hand registers.
REQ-016 novo_jogo in IDLE clears both hands' hard sums, ace flags and carta next edge.
REQ-017 novo_jogo in LER/SOMAR is ignored; the draw completes normally.
REQ-018 novo_jogo and comprar in the same cycle: novo_jogo wins; comprar is dropped.
REQ-019 embaralhar_ok falling mid-draw does not abort the draw; it only gates new acceptances.

Reset
REQ-020 reset=0 sampled at a clock edge returns to IDLE and sets ler_endereco=0, carta=0, carta_valida=0, ocupado=0, both hard sums=0 and ace flags=0, so pontos=0, estouro=0 and baralho_vazio=0.
REQ-021 Reset asserted in LER or SOMAR abandons the draw: no carta_valida pulse, pointer=0.

Structure
REQ-022 A shared package holds the FSM state encoding, N_CARTAS, LIMITE, ace and court-card code constants, and the ace bonus (10).
REQ-023 One sub-module, acumulador_mao (hard sum, ace flag, pontos, estouro), instantiated twice: player and dealer.

Verification
REQ-024 Bench model: unshuffled deck (addr k -> k%13==0 ? 1 : k%13<10 ? k%13+1 : 11), embaralhar_ok=1.
REQ-025 Scenario A: player draws twice after reset -> carta 1 then 2; pontos_jogador 11 then 13; ler_endereco=2; carta_valida exactly 2 cycles after each comprar.
REQ-026 Scenario B: player draws 7 cards (A..7) -> pontos_jogador 11,13,16,20,15,21,28; estouro_jogador=1 after the 7th; an 8th comprar is dropped, pointer stays 7.
REQ-027 Scenario C: dealer draws addresses 10,11 (after 10 skipped draws to player, then novo_jogo) -> pontos_dealer 10 then 20; pontos_jogador=0; ler_endereco=12.
REQ-028 Scenario D: comprar held high 6 cycles -> exactly 2 draws accepted; comprar+novo_jogo in the same cycle -> no draw, hands cleared.
REQ-029 Scenario E: 52 draws alternating hands with novo_jogo whenever a hand busts -> baralho_vazio=1, ler_endereco=52, further comprar ignored; reset=0 during SOMAR -> no pulse, pointer 0.

Source files
------------

// File: rtl/mao_pontuacao_pkg.sv
// ============================================================================
// mao_pontuacao_pkg : shared types and constants for the hand-scoring block
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package mao_pontuacao_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LER   = 2'd1,
      SOMAR = 2'd2
   } estado_t;

   localparam int         N_CARTAS_PADRAO = 52;
   localparam int         LIMITE_PADRAO   = 21;
   localparam logic [3:0] CODIGO_AS       = 4'd1;
   localparam logic [3:0] CODIGO_FIGURA   = 4'd11;
   localparam logic [4:0] BONUS_AS        = 5'd10;

   // Unknown codes score nothing but still consume a deck slot.
   function automatic logic [4:0] valor_carta(input logic [3:0] codigo);
      if (codigo == CODIGO_FIGURA)
         return 5'd10;
      else if (codigo >= 4'd1 && codigo <= 4'd10)
         return {1'b0, codigo};
      else
         return 5'd0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mao_pontuacao_acumulador.sv
// ============================================================================
// acumulador_mao : one hand's hard sum, ace flag, best score and bust flag
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module acumulador_mao
   import mao_pontuacao_pkg::*;
#(
   parameter int LIMITE = LIMITE_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       limpar,
   input  logic       somar,
   input  logic [3:0] carta,
   output logic [4:0] pontos,
   output logic       estouro
);

   localparam logic [5:0] c_LIMITE = 6'(LIMITE);

   logic [4:0] r_duro;
   logic       r_as;
   logic [5:0] w_soma;

   assign w_soma = {1'b0, r_duro} + {1'b0, valor_carta(carta)};

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_duro <= 5'd0;
         r_as   <= 1'b0;
      end else if (limpar) begin
         r_duro <= 5'd0;
         r_as   <= 1'b0;
      end else if (somar) begin
         r_duro <= w_soma[5] ? 5'd31 : w_soma[4:0];
         if (carta == CODIGO_AS)
            r_as <= 1'b1;
      end
   end

   // One ace counts as 11 only while that cannot push the hand past 21.
   assign pontos  = (r_as && r_duro <= 5'd11) ? r_duro + BONUS_AS : r_duro;
   assign estouro = {1'b0, pontos} > c_LIMITE;

endmodule

`default_nettype wire

// File: rtl/mao_pontuacao.sv
// ============================================================================
// mao_pontuacao : deals cards from a shuffled deck into player/dealer hands
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mao_pontuacao
   import mao_pontuacao_pkg::*;
#(
   parameter int N_CARTAS = N_CARTAS_PADRAO,
   parameter int LIMITE   = LIMITE_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       embaralhar_ok,
   input  logic       novo_jogo,
   input  logic       comprar,
   input  logic       destino,
   input  logic [3:0] q,
   output logic [5:0] ler_endereco,
   output logic [3:0] carta,
   output logic       carta_valida,
   output logic       ocupado,
   output logic [4:0] pontos_jogador,
   output logic [4:0] pontos_dealer,
   output logic       estouro_jogador,
   output logic       estouro_dealer,
   output logic       baralho_vazio
);

   localparam logic [5:0] c_FIM = 6'(N_CARTAS);

   estado_t    r_estado;
   logic       r_destino;
   logic [5:0] r_endereco;
   logic [3:0] r_carta;
   logic       r_valida;
   logic       r_ocupado;

   logic w_vazio;
   logic w_estouro_sel;
   logic w_aceita;
   logic w_limpar;
   logic w_somar;

   assign w_vazio       = (r_endereco == c_FIM);
   assign w_estouro_sel = destino ? estouro_dealer : estouro_jogador;
   assign w_aceita      = (r_estado == IDLE) && comprar && embaralhar_ok &&
                          !w_vazio && !w_estouro_sel && !novo_jogo;
   assign w_limpar      = (r_estado == IDLE) && novo_jogo;
   assign w_somar       = (r_estado == SOMAR);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_estado   <= IDLE;
         r_destino  <= 1'b0;
         r_endereco <= 6'd0;
         r_carta    <= 4'd0;
         r_valida   <= 1'b0;
         r_ocupado  <= 1'b0;
      end else begin
         r_valida <= 1'b0;
         case (r_estado)
            IDLE: begin
               if (novo_jogo) begin
                  r_carta <= 4'd0;
               end else if (w_aceita) begin
                  r_destino <= destino;
                  r_estado  <= LER;
                  r_ocupado <= 1'b1;
               end
            end
            LER: begin
               r_carta  <= q;
               r_estado <= SOMAR;
            end
            SOMAR: begin
               // The pointer stops at N_CARTAS; acceptance already blocks at empty.
               if (r_endereco != c_FIM)
                  r_endereco <= r_endereco + 6'd1;
               r_valida  <= 1'b1;
               r_estado  <= IDLE;
               r_ocupado <= 1'b0;
            end
            default: begin
               r_estado  <= IDLE;
               r_ocupado <= 1'b0;
            end
         endcase
      end
   end

   acumulador_mao #(.LIMITE(LIMITE)) u_jogador (
      .clock   (clock),
      .reset   (reset),
      .limpar  (w_limpar),
      .somar   (w_somar && !r_destino),
      .carta   (r_carta),
      .pontos  (pontos_jogador),
      .estouro (estouro_jogador)
   );

   acumulador_mao #(.LIMITE(LIMITE)) u_dealer (
      .clock   (clock),
      .reset   (reset),
      .limpar  (w_limpar),
      .somar   (w_somar && r_destino),
      .carta   (r_carta),
      .pontos  (pontos_dealer),
      .estouro (estouro_dealer)
   );

   assign ler_endereco  = r_endereco;
   assign carta         = r_carta;
   assign carta_valida  = r_valida;
   assign ocupado       = r_ocupado;
   assign baralho_vazio = w_vazio;

endmodule

`default_nettype wire

// File: tb/tb_mao_pontuacao.sv
// ============================================================================
// tb_mao_pontuacao : directed self-checking bench for mao_pontuacao
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mao_pontuacao;

   logic       clock = 1'b0;
   logic       reset;
   logic       embaralhar_ok;
   logic       novo_jogo;
   logic       comprar;
   logic       destino;
   logic [3:0] q;
   logic [5:0] ler_endereco;
   logic [3:0] carta;
   logic       carta_valida;
   logic       ocupado;
   logic [4:0] pontos_jogador;
   logic [4:0] pontos_dealer;
   logic       estouro_jogador;
   logic       estouro_dealer;
   logic       baralho_vazio;

   int total = 0;
   int bad   = 0;
   int m_duro [2];
   bit m_as   [2];

   always #5 clock = ~clock;

   // Unshuffled deck: A,2..10,J,Q,K repeating.
   function automatic logic [3:0] codigo_deck(input logic [5:0] a);
      int r;
      r = int'(a) % 13;
      if (r == 0)      return 4'd1;
      else if (r < 10) return 4'(r + 1);
      else             return 4'd11;
   endfunction

   assign q = codigo_deck(ler_endereco);

   mao_pontuacao dut (
      .clock           (clock),
      .reset           (reset),
      .embaralhar_ok   (embaralhar_ok),
      .novo_jogo       (novo_jogo),
      .comprar         (comprar),
      .destino         (destino),
      .q               (q),
      .ler_endereco    (ler_endereco),
      .carta           (carta),
      .carta_valida    (carta_valida),
      .ocupado         (ocupado),
      .pontos_jogador  (pontos_jogador),
      .pontos_dealer   (pontos_dealer),
      .estouro_jogador (estouro_jogador),
      .estouro_dealer  (estouro_dealer),
      .baralho_vazio   (baralho_vazio)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int m_pontos(input int h);
      return (m_as[h] && m_duro[h] <= 11) ? m_duro[h] + 10 : m_duro[h];
   endfunction

   function automatic void m_limpar();
      m_duro[0] = 0; m_duro[1] = 0; m_as[0] = 1'b0; m_as[1] = 1'b0;
   endfunction

   task automatic m_somar(input int h, input logic [3:0] c);
      int v;
      v = (c == 4'd11) ? 10 : int'(c);
      m_duro[h] = (m_duro[h] + v > 31) ? 31 : m_duro[h] + v;
      if (c == 4'd1) m_as[h] = 1'b1;
   endtask

   // Accepted draw: checks busy and the two-cycle pulse latency.
   task automatic draw(input logic dest, input string tag);
      @(negedge clock);
      comprar = 1'b1; destino = dest;
      @(posedge clock); #1;
      comprar = 1'b0; destino = 1'b0;
      chk({tag, " ocupado"}, 32'(ocupado), 32'd1);
      @(posedge clock); #1;
      chk({tag, " valida_cedo"}, 32'(carta_valida), 32'd0);
      @(posedge clock); #1;
      chk({tag, " valida"}, 32'(carta_valida), 32'd1);
   endtask

   task automatic pulso_novo();
      @(negedge clock);
      novo_jogo = 1'b1;
      @(posedge clock); #1;
      novo_jogo = 1'b0;
   endtask

   task automatic tenta_descartada(input string tag);
      @(negedge clock);
      comprar = 1'b1;
      @(posedge clock); #1;
      comprar = 1'b0;
      chk({tag, " ocupado"}, 32'(ocupado), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      chk({tag, " valida"}, 32'(carta_valida), 32'd0);
   endtask

   task automatic aplica_reset();
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   int pulsos;

   initial begin
      reset = 1'b0; embaralhar_ok = 1'b1; novo_jogo = 1'b0;
      comprar = 1'b0; destino = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst endereco", 32'(ler_endereco), 32'd0);
      chk("rst carta", 32'(carta), 32'd0);
      chk("rst valida", 32'(carta_valida), 32'd0);
      chk("rst ocupado", 32'(ocupado), 32'd0);
      chk("rst pj", 32'(pontos_jogador), 32'd0);
      chk("rst pd", 32'(pontos_dealer), 32'd0);
      chk("rst estouros", {30'd0, estouro_jogador, estouro_dealer}, 32'd0);
      chk("rst vazio", 32'(baralho_vazio), 32'd0);
      reset = 1'b1;

      // Scenario A
      draw(1'b0, "A1");
      chk("A1 carta", 32'(carta), 32'd1);
      chk("A1 pj", 32'(pontos_jogador), 32'd11);
      draw(1'b0, "A2");
      chk("A2 carta", 32'(carta), 32'd2);
      chk("A2 pj", 32'(pontos_jogador), 32'd13);
      chk("A endereco", 32'(ler_endereco), 32'd2);

      // Scenario B: cards 3..7 continue the same hand
      draw(1'b0, "B3"); chk("B3 pj", 32'(pontos_jogador), 32'd16);
      draw(1'b0, "B4"); chk("B4 pj", 32'(pontos_jogador), 32'd20);
      draw(1'b0, "B5"); chk("B5 pj", 32'(pontos_jogador), 32'd15);
      draw(1'b0, "B6"); chk("B6 pj", 32'(pontos_jogador), 32'd21);
      chk("B6 estouro", 32'(estouro_jogador), 32'd0);
      draw(1'b0, "B7"); chk("B7 pj", 32'(pontos_jogador), 32'd28);
      chk("B7 carta", 32'(carta), 32'd7);
      chk("B7 estouro", 32'(estouro_jogador), 32'd1);
      tenta_descartada("B8");
      chk("B8 endereco", 32'(ler_endereco), 32'd7);

      // Scenario C: player takes 7..9, then dealer takes 10,11
      pulso_novo();
      chk("C novo pj", 32'(pontos_jogador), 32'd0);
      chk("C novo carta", 32'(carta), 32'd0);
      draw(1'b0, "C7"); chk("C7 pj", 32'(pontos_jogador), 32'd8);
      draw(1'b0, "C8"); chk("C8 pj", 32'(pontos_jogador), 32'd17);
      draw(1'b0, "C9"); chk("C9 pj", 32'(pontos_jogador), 32'd27);
      pulso_novo();
      draw(1'b1, "C10"); chk("C10 pd", 32'(pontos_dealer), 32'd10);
      chk("C10 carta", 32'(carta), 32'd11);
      draw(1'b1, "C11"); chk("C11 pd", 32'(pontos_dealer), 32'd20);
      chk("C pj", 32'(pontos_jogador), 32'd0);
      chk("C endereco", 32'(ler_endereco), 32'd12);

      embaralhar_ok = 1'b0;
      tenta_descartada("sem_embaralhar");
      chk("sem_embaralhar endereco", 32'(ler_endereco), 32'd12);
      embaralhar_ok = 1'b1;

      // Scenario D: comprar held for six edges
      pulsos = 0;
      @(negedge clock);
      comprar = 1'b1; destino = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         if (carta_valida) pulsos++;
      end
      comprar = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("D pulsos", 32'(pulsos), 32'd2);
      chk("D endereco", 32'(ler_endereco), 32'd14);
      chk("D pj", 32'(pontos_jogador), 32'd21);
      @(negedge clock);
      comprar = 1'b1; novo_jogo = 1'b1;
      @(posedge clock); #1;
      comprar = 1'b0; novo_jogo = 1'b0;
      chk("D junto ocupado", 32'(ocupado), 32'd0);
      chk("D junto pj", 32'(pontos_jogador), 32'd0);
      chk("D junto pd", 32'(pontos_dealer), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      chk("D junto endereco", 32'(ler_endereco), 32'd14);
      chk("D junto valida", 32'(carta_valida), 32'd0);

      // Scenario E: whole deck, alternating hands
      aplica_reset();
      m_limpar();
      for (int i = 0; i < 52; i++) begin
         int h;
         h = i % 2;
         if (m_pontos(h) > 21) begin
            pulso_novo();
            m_limpar();
         end
         draw(h[0], "E");
         m_somar(h, codigo_deck(6'(i)));
         chk("E pontos", 32'(h == 0 ? pontos_jogador : pontos_dealer), 32'(m_pontos(h)));
      end
      chk("E vazio", 32'(baralho_vazio), 32'd1);
      chk("E endereco", 32'(ler_endereco), 32'd52);
      pulso_novo();
      tenta_descartada("E cheio");
      chk("E cheio endereco", 32'(ler_endereco), 32'd52);

      aplica_reset();
      draw(1'b0, "E pre");
      chk("E pre endereco", 32'(ler_endereco), 32'd1);
      @(negedge clock);
      comprar = 1'b1;
      @(posedge clock); #1;
      comprar = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      chk("E rst valida", 32'(carta_valida), 32'd0);
      chk("E rst endereco", 32'(ler_endereco), 32'd0);
      chk("E rst ocupado", 32'(ocupado), 32'd0);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("E rst valida depois", 32'(carta_valida), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
